// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding and the default bit period.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a falling-edge
// detector on the synchronised value. All flops reset to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall_pulse
);

  logic meta;
  logic rx_d;

  // synchroniser chain and one-cycle delay for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      rx_d <= rx_s;
    end
  end

  assign fall_pulse = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver on the system clock: mid-bit sampling from an
// internal bit-period counter, parity/framing/overrun checks, valid/ack output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int H       = CLKS_PER_BIT / 2;
  localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int IDX_W   = $clog2(BIT_MAX);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_rx_param: illegal parameter value");
  end

  function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = (^d) ^ p;
    if (PARITY == PAR_ODD) return ~x;
    else if (PARITY == PAR_EVEN) return x;
    else return 1'b0;
  endfunction

  logic                 rx_s;
  logic                 fall_pulse;
  rx_state_t            state;
  rx_state_t            state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 pbit;
  logic                 ferr_acc;
  logic                 tick;
  logic                 last_data;
  logic                 last_stop;
  logic                 done;
  logic                 frame_now;

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_s       (rx_s),
    .fall_pulse (fall_pulse)
  );

  // START samples half a bit after t0; every later sample is a full bit apart
  assign tick      = (state == ST_START) ? (cnt == CNT_W'(H - 1)) : (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_data = (idx == IDX_W'(DATA_BITS - 1));
  assign last_stop = (idx == IDX_W'(STOP_BITS - 1));
  assign frame_now = ferr_acc | ~rx_s;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // next-state logic and frame completion strobe
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      ST_IDLE:   if (fall_pulse) state_nx = ST_START; else state_nx = ST_IDLE;
      ST_START:  if (tick) state_nx = rx_s ? ST_IDLE : ST_DATA; else state_nx = ST_START;
      ST_DATA:   if (tick && last_data) state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                 else state_nx = ST_DATA;
      ST_PARITY: if (tick) state_nx = ST_STOP; else state_nx = ST_PARITY;
      ST_STOP: begin
        if (tick && last_stop) begin
          state_nx = ST_IDLE;
          done     = 1'b1;
        end else begin
          state_nx = ST_STOP;
        end
      end
      default:   state_nx = ST_IDLE;
    endcase
  end

  // bit-period counter, bit index, shift register and per-frame flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= CNT_W'(0);
      idx      <= IDX_W'(0);
      shreg    <= DATA_BITS'(0);
      pbit     <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == ST_IDLE || tick) cnt <= CNT_W'(0);
      else                          cnt <= cnt + CNT_W'(1);
      if (state_nx != state) idx <= IDX_W'(0);
      else if (tick)         idx <= idx + IDX_W'(1);
      else                   idx <= idx;
      if (state == ST_DATA && tick) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (state == ST_PARITY && tick) pbit <= rx_s;
      if (state == ST_START) ferr_acc <= 1'b0;
      else if (state == ST_STOP && tick && !rx_s) ferr_acc <= 1'b1;
    end
  end

  // output word register with hold-until-ack and overrun drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= DATA_BITS'(0);
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ack) begin
          rx_data    <= shreg;
          frame_err  <= frame_now;
          parity_err <= calc_parity_err(shreg, pbit);
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances (8N1, 8E1, 7N2) at
// 16 clocks per bit, directed frames, a negedge monitor that pops expectations.
module tb_uart_rx_param;
  import uart_pkg::*;

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_a, rx_b, rx_c, ack_a, ack_b, ack_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c, fe_a, fe_b, fe_c, pe_a, pe_b, pe_c, ov_a, ov_b, ov_c;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c0;
  exp_t qa[$], qb[$], qc[$];
  logic vprev[3];
  logic aprev[3];
  int ovr[3];
  int new_cyc[3];

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a), .rx_ack(ack_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b), .rx_ack(ack_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx(rx_c), .rx_data(data_c), .rx_valid(valid_c), .rx_ack(ack_c),
    .frame_err(fe_c), .parity_err(pe_c), .overrun_err(ov_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic set_ack(input int d, input logic v);
    case (d)
      0: ack_a = v;
      1: ack_b = v;
      default: ack_c = v;
    endcase
  endtask

  function automatic logic [15:0] get_out(input int d);
    case (d)
      0: return {3'b000, valid_a, fe_a, pe_a, ov_a, 1'b0, data_a};
      1: return {3'b000, valid_b, fe_b, pe_b, ov_b, 1'b0, data_b};
      default: return {3'b000, valid_c, fe_c, pe_c, ov_c, 2'b00, data_c};
    endcase
  endfunction

  function automatic logic get_valid(input int d);
    logic [15:0] o;
    o = get_out(d);
    return o[12];
  endfunction

  function automatic logic [8:0] get_data(input int d);
    logic [15:0] o;
    o = get_out(d);
    return o[8:0];
  endfunction

  task automatic push(input int d, input logic [8:0] data, input logic fe, input logic pe);
    exp_t e;
    e = '{d: data, fe: fe, pe: pe};
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic send(input int d, input logic [8:0] data, input int nbits, input int with_par,
                      input logic pbit, input logic s1, input logic s2, input int nstop);
    set_rx(d, 1'b0);
    wclk(16);
    for (int i = 0; i < nbits; i++) begin
      set_rx(d, data[i]);
      wclk(16);
    end
    if (with_par != 0) begin
      set_rx(d, pbit);
      wclk(16);
    end
    set_rx(d, s1);
    wclk(16);
    if (nstop == 2) begin
      set_rx(d, s2);
      wclk(16);
    end
    set_rx(d, 1'b1);
    wclk(4);
  endtask

  task automatic wait_valid(input int d);
    for (int i = 0; i < 400; i++) begin
      if (get_valid(d)) break;
      wclk(1);
    end
    check("valid_timeout", d, 16'(get_valid(d)), 16'd1);
  endtask

  task automatic ack_pulse(input int d);
    set_ack(d, 1'b1);
    wclk(1);
    set_ack(d, 1'b0);
  endtask

  task automatic mon_step(input int d, input logic v, input logic a, input logic [8:0] dat,
                          input logic fe, input logic pe, input logic ov);
    exp_t e;
    bit have;
    have = 1'b0;
    e = '0;
    if (ov) ovr[d]++;
    if (v && (!vprev[d] || aprev[d])) begin
      new_cyc[d] = cyc;
      case (d)
        0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
        1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
        default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word dut%0d: got %h expected none", d, dat);
      end else begin
        check("word_data", d, 16'(dat), 16'(e.d));
        check("word_frame_err", d, 16'(fe), 16'(e.fe));
        check("word_parity_err", d, 16'(pe), 16'(e.pe));
      end
    end
    vprev[d] = v;
    aprev[d] = a;
  endtask

  // monitor: a new word is presented when valid rises or is reloaded under ack
  always @(negedge clk) begin
    mon_step(0, valid_a, ack_a, {1'b0, data_a}, fe_a, pe_a, ov_a);
    mon_step(1, valid_b, ack_b, {1'b0, data_b}, fe_b, pe_b, ov_b);
    mon_step(2, valid_c, ack_c, {2'b00, data_c}, fe_c, pe_c, ov_c);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      vprev[i] = 1'b0; aprev[i] = 1'b0; ovr[i] = 0; new_cyc[i] = 0;
    end
    rst = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;
    wclk(3);
    for (int d = 0; d < 3; d++) check("reset_outputs", d, get_out(d), 16'h0000);
    rst = 1'b1;
    wclk(2);

    // 8N1 0x55: latency to rx_valid and drop after ack
    push(0, 9'h055, 1'b0, 1'b0);
    c0 = cyc;
    fork
      send(0, 9'h055, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        wait_valid(0);
        wclk(5);
        ack_pulse(0);
        check("valid_drop_after_ack", 0, 16'(valid_a), 16'd0);
        check("data_held_after_ack", 0, 16'(data_a), 16'h0055);
      end
    join
    check("valid_latency", 0, 16'(new_cyc[0] - c0), 16'd155);

    // bad stop bit, then a break yields exactly one frame
    push(0, 9'h07E, 1'b1, 1'b0);
    send(0, 9'h07E, 8, 0, 1'b0, 1'b0, 1'b1, 1);
    wait_valid(0);
    ack_pulse(0);
    push(0, 9'h000, 1'b1, 1'b0);
    set_rx(0, 1'b0);
    wclk(200);
    wait_valid(0);
    ack_pulse(0);
    wclk(30 * 16 - 201);
    set_rx(0, 1'b1);
    wclk(64);
    check("break_queue_empty", 0, 16'(qa.size()), 16'd0);
    check("break_valid_idle", 0, 16'(valid_a), 16'd0);

    // 4-clock glitch is rejected as a false start
    set_rx(0, 1'b0);
    wclk(4);
    set_rx(0, 1'b1);
    wclk(7);
    check("glitch_state_idle", 0, 16'(u_a.state), 16'(ST_IDLE));
    wclk(200);
    check("glitch_no_valid", 0, 16'(valid_a), 16'd0);

    // overrun: second frame dropped while first is unacknowledged
    push(0, 9'h011, 1'b0, 1'b0);
    send(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    send(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    wclk(5);
    check("overrun_keep_data", 0, 16'(data_a), 16'h0011);
    check("overrun_pulses", 0, 16'(ovr[0]), 16'd1);
    check("overrun_valid_held", 0, 16'(valid_a), 16'd1);
    ack_pulse(0);

    // ack on the completion cycle replaces the word without overrun
    push(0, 9'h011, 1'b0, 1'b0);
    send(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    push(0, 9'h022, 1'b0, 1'b0);
    fork
      send(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
      begin
        wclk(154);
        set_ack(0, 1'b1);
        wclk(1);
        set_ack(0, 1'b0);
      end
    join
    check("ack_on_done_valid", 0, 16'(valid_a), 16'd1);
    check("ack_on_done_data", 0, 16'(data_a), 16'h0022);
    check("ack_on_done_no_overrun", 0, 16'(ovr[0]), 16'd1);
    ack_pulse(0);

    // even parity
    push(1, 9'h0A3, 1'b0, 1'b1);
    send(1, 9'h0A3, 8, 1, 1'b1, 1'b1, 1'b1, 1);
    wait_valid(1);
    ack_pulse(1);
    push(1, 9'h0A3, 1'b0, 1'b0);
    send(1, 9'h0A3, 8, 1, 1'b0, 1'b1, 1'b1, 1);
    wait_valid(1);
    ack_pulse(1);
    push(1, 9'h007, 1'b0, 1'b0);
    send(1, 9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 1);
    wait_valid(1);
    ack_pulse(1);

    // 7 data bits, 2 stop bits, reset mid-frame
    push(2, 9'h03C, 1'b1, 1'b0);
    send(2, 9'h03C, 7, 0, 1'b0, 1'b1, 1'b0, 2);
    wclk(2);
    fork
      send(2, 9'h070, 7, 0, 1'b0, 1'b1, 1'b1, 2);
      begin
        wclk(88);
        rst = 1'b0;
        wclk(1);
        check("midframe_reset_outputs", 2, get_out(2), 16'h0000);
        rst = 1'b1;
      end
    join
    wclk(50);
    check("aborted_frame_no_valid", 2, 16'(valid_c), 16'd0);
    push(2, 9'h03C, 1'b0, 1'b0);
    send(2, 9'h03C, 7, 0, 1'b0, 1'b1, 1'b1, 2);
    wait_valid(2);
    check("stop2_data", 2, 16'(get_data(2)), 16'h003C);
    ack_pulse(2);
    push(2, 9'h03C, 1'b1, 1'b0);
    send(2, 9'h03C, 7, 0, 1'b0, 1'b0, 1'b1, 2);
    wait_valid(2);
    ack_pulse(2);

    wclk(20);
    check("final_queue", 0, 16'(qa.size()), 16'd0);
    check("final_queue", 1, 16'(qb.size()), 16'd0);
    check("final_queue", 2, 16'(qc.size()), 16'd0);
    check("final_overruns", 1, 16'(ovr[1]), 16'd0);
    check("final_overruns", 2, 16'(ovr[2]), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Runs entirely on the system clock, using an internal bit-period counter instead of a divided clock. Adds configurable data width, parity and stop bits, false-start rejection, framing/parity/overrun detection, and a valid/ack output handshake. Sits between the rx pin and the consumer logic (FIFO or command decoder).

Parameters:
CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200); legal range >= 4
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits checked; 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx  in  1  serial line, asynchronous to clk, idle high
rx_data  out  DATA_BITS  received word, LSB first on the line
rx_valid  out  1  rx_data, frame_err and parity_err are valid; held until acknowledged
rx_ack  in  1  consumer takes the word when rx_valid & rx_ack
frame_err  out  1  a sampled stop bit was 0 (qualified by rx_valid)
parity_err  out  1  parity mismatch (qualified by rx_valid); always 0 when PARITY = 0
overrun_err  out  1  one-cycle pulse: a frame completed while rx_valid was high and not acked; that frame is dropped

Behaviour:
- Reset (async, rst = 0): rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun_err = 0; state IDLE; synchroniser flops = 1.
- rx passes through a 2-flop synchroniser; edge detection uses the synchronised value and its one-cycle delay.
- t0 is the clk cycle in which the synchronised rx first reads 0 after reading 1 while in IDLE. H = CLKS_PER_BIT/2 (integer division).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START at t0; the bit counter clears.
- START: rx is sampled at t0 + H.
  - Sample = 1: false start; go to IDLE with no output and no error.
  - Sample = 0: go to DATA.
- DATA: bit i (i = 0..DATA_BITS-1) is sampled at t0 + H + (i+1)*CLKS_PER_BIT and shifted in LSB first.
  - After the last bit, go to PARITY if PARITY != 0, else STOP.
- PARITY: one sample, one bit period after the last data bit.
  - Odd parity expects XOR(data, pbit) = 1; even parity expects XOR(data, pbit) = 0.
- STOP: STOP_BITS samples at one-bit-period spacing. Any 0 sets the frame's frame_err.
- Completion: on the cycle after the final stop sample (mid stop bit), go to IDLE. New start edges are accepted from then on.
- Break (line held low): the frame completes with frame_err = 1. IDLE then needs rx = 1 before a new falling edge, so exactly one frame is reported per break.
- Output register on completion:
  - rx_valid = 0, or rx_ack = 1 in the same cycle: load rx_data, frame_err and parity_err; rx_valid = 1 next cycle.
  - rx_valid = 1 and rx_ack = 0: keep the old word and flags; overrun_err = 1 for exactly one cycle.
- Ack with no completion: rx_valid = 0 next cycle; rx_data and the flags hold their values.
- The bit-period counter is $clog2(CLKS_PER_BIT) bits wide and wraps at CLKS_PER_BIT-1. The data/stop bit index is sized for max(DATA_BITS, STOP_BITS).
- Reset asserted mid-frame aborts the frame immediately; nothing is delivered.
- Illegal parameter values cause an elaboration-time error.

Decomposition:
- Shared package uart_pkg:
  - parity encoding constants PAR_NONE / PAR_ODD / PAR_EVEN
  - rx state encoding
  - default baud constant 868
- One sub-module, uart_rx_sync: 2-flop synchroniser plus falling-edge detect. Outputs are rx_s and fall_pulse; reset value is 1.
- The FSM, counters, shift register and output register stay in uart_rx_param.

Test Plan:
- CLKS_PER_BIT = 16, 8N1; send 0x55 and ack 5 cycles later -> rx_data = 0x55, rx_valid rises at t0 + 8 + 9*16 + 1 and drops the cycle after ack; all errors 0.
- PARITY = 2, send 0xA3 with parity bit 1 (correct is 0) -> rx_data = 0xA3, parity_err = 1. Resend with parity bit 0 -> parity_err = 0.
- Stop bit forced to 0 on 0x7E -> frame_err = 1, rx_data = 0x7E. Then hold rx low for 30 bit times -> exactly one further frame with 0x00 and frame_err = 1; nothing more until rx returns high.
- Glitch: rx low for 4 clocks, then high -> no rx_valid, FSM back in IDLE by t0 + 9.
- Send 0x11 then 0x22 with no ack -> rx_data stays 0x11, overrun_err pulses once. Repeat with rx_ack asserted on the 0x22 completion cycle -> rx_data = 0x22, rx_valid stays 1, no overrun.
- STOP_BITS = 2, DATA_BITS = 7: assert rst during data bit 4 -> all outputs 0. Next frame 0x3C is received correctly, with the second stop bit checked (forcing it to 0 sets frame_err).
